// File: rtl/event_pacer.sv
// Queues event requests in the clk_s domain and replays them on event_s as
// registered pulses separated by low gaps, one rising edge per event.
module event_pacer #(
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned HIGH_CYC = 1,
   parameter int unsigned GAP_CYC  = 1
) (
   input  logic             clk_s,
   input  logic             rstn_s,
   input  logic             evt_req,
   input  logic             clr,
   output logic             event_s,
   output logic [CNT_W-1:0] pending,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned TMR_MAX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] HIGH_LD  = TMR_W'(HIGH_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]       state_q,    state_d;
   logic [TMR_W-1:0] timer_q,    timer_d;
   logic             event_q,    event_d;
   logic [CNT_W-1:0] pending_q,  pending_d;
   logic             overflow_q, overflow_d;
   logic             launch;

   // State, pulse and queue registers
   always_ff @(posedge clk_s or negedge rstn_s) begin
      if (!rstn_s) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         event_q    <= 1'b0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         event_q    <= event_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   // Pulse timing FSM plus pending counter; a launch pops one queued event
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      event_d    = event_q;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      launch     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pending_q != '0) launch = 1'b1;
         end
         ST_HIGH: begin
            if (timer_q == '0) begin
               state_d = ST_GAP;
               event_d = 1'b0;
               timer_d = GAP_LD;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (timer_q == '0) begin
               if (pending_q != '0) launch  = 1'b1;
               else                 state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            event_d = 1'b0;
            timer_d = '0;
         end
      endcase

      if (launch) begin
         state_d = ST_HIGH;
         event_d = 1'b1;
         timer_d = HIGH_LD;
      end

      // A request coinciding with a launch nets to zero and is never dropped
      if (evt_req && !launch) begin
         if (pending_q == PEND_MAX) overflow_d = 1'b1;
         else                       pending_d  = pending_q + CNT_W'(1);
      end else if (!evt_req && launch) begin
         pending_d = pending_q - CNT_W'(1);
      end

      if (clr) begin
         state_d    = ST_IDLE;
         timer_d    = '0;
         event_d    = 1'b0;
         pending_d  = '0;
         overflow_d = 1'b0;
      end
   end

   assign event_s  = event_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != ST_IDLE) || (pending_q != '0);

endmodule
